// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the multi-cycle shift sequencer.
// ROL op encoding is only meaningful when SHIFT_SEQ_ROTATE_EN is defined.
package shift_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/shift_stage.sv
// Single combinational power-of-two shift step: acc shifted/rotated by 2^k.
// Rotate-left for op 11 is built only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W,
  parameter int unsigned K_W     = $clog2(SHAMT_W)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned AW = SHAMT_W + 1;

  logic [AW-1:0] amt;

  always_comb begin
    amt    = AW'(1) << k;
    result = acc << amt;
    case (op)
      OP_SRL: result = acc >> amt;
      OP_SRA: result = WIDTH'($signed(acc) >>> amt);
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROL: result = (acc << amt) | (acc >> (AW'(WIDTH) - amt));
`endif
      default: result = acc << amt;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer reusing one shift stage for up to SHAMT_W cycles per request.
// Optional rotate-left (op 11) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  localparam int unsigned K_W = $clog2(SHAMT_W);

  shift_state_t       state;
  logic [WIDTH-1:0]   acc;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   stage_out;

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .K_W     (K_W)
  ) u_stage (
    .acc    (acc),
    .op     (op),
    .k      (k),
    .result (stage_out)
  );

  // Flush wins over a request arriving in the same cycle.
  assign req_ready = (state == ST_IDLE) && !flush;
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = acc;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      op    <= '0;
      shamt <= '0;
      k     <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            acc   <= req_data;
            op    <= req_op;
            shamt <= req_shamt;
            k     <= '0;
            state <= (req_shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shamt[k]) begin
            acc <= stage_out;
          end
          // Stop as soon as no higher shamt bits remain.
          if ((shamt >> (K_W'(k + K_W'(1)))) == '0) begin
            state <= ST_DONE;
          end else begin
            k <= K_W'(k + K_W'(1));
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl; expected results come from a plain
// arithmetic model. Rotate expectations follow SHIFT_SEQ_ROTATE_EN.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;

  int passed = 0;
  int total  = 0;

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] sh);
    case (op)
      2'b01: return d >> sh;
      2'b10: return 32'($signed(d) >>> sh);
`ifdef SHIFT_SEQ_ROTATE_EN
      2'b11: return (sh == 5'd0) ? d : ((d << sh) | (d >> (6'd32 - 6'(sh))));
`endif
      default: return d << sh;
    endcase
  endfunction

  // Cycles spent shifting: position of the highest set bit plus one.
  function automatic int latency(input logic [4:0] sh);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) if (sh[i]) n = i + 1;
    return n;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                        input int hold);
    logic [31:0] exp;
    int          cyc;
    exp = model(op, d, sh);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_shamt = sh;
    rsp_ready = (hold == 0);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Keep a junk request asserted while busy; it must be ignored.
    req_op    = 2'($urandom);
    req_data  = $urandom;
    req_shamt = 5'($urandom);
    cyc = 0;
    while (!rsp_valid && cyc < 12) begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    check("latency", 32'(cyc), 32'(latency(sh)));
    check("rsp_data", rsp_data, exp);
    check("busy_done", 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_data  = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, exp);
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = '0;
    req_shamt = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan.
    run_op(2'b00, 32'h0000_00F0, 5'd0, 0);
    run_op(2'b00, 32'h0000_0001, 5'd4, 0);
    run_op(2'b10, 32'h8000_0000, 5'd31, 0);
    run_op(2'b01, 32'h8000_0000, 5'd31, 4);
    run_op(2'b11, 32'h8000_0001, 5'd1, 0);
    run_op(2'b10, 32'h7FFF_FFFF, 5'd16, 1);

    // Flush during SHIFT: back to IDLE at the next edge, no response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_data = 32'h1234_5678; req_shamt = 5'd31;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Flush colliding with a request in IDLE: request dropped.
    req_valid = 1'b1; req_shamt = 5'd3; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 32'd0);

    // Randomised operations, including op 11.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-SHIFT takes effect without a clock edge.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_data = 32'hDEAD_BEEF; req_shamt = 5'd30;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 32'h0000_0003, 5'd2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the ALU's shift resource. One shared 32-bit shift stage is reused across up to 5 cycles, one power-of-two step per cycle, instead of a full 5-level barrel shifter.
- Accepts SLL/SRL/SRA requests over a valid/ready handshake and returns the result over a second valid/ready handshake.
- Sits between the ALU issue logic and the writeback mux. Handles one operation in flight at a time.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort of the in-flight operation
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (ROL only with the optional feature)
- req_data  input  WIDTH  operand to shift
- req_shamt  input  SHAMT_W  shift amount (low bits of the second operand)
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts the result
- rsp_data  output  WIDTH  shifted result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; acc, op and shamt registers all 0.
  - req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- States: IDLE, SHIFT, DONE. State is binary-encoded.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch acc=req_data, op=req_op, shamt=req_shamt, and set stage index k=0.
  - Next state is DONE if req_shamt==0, else SHIFT.
- SHIFT (req_ready=0), at each edge:
  - If shamt[k]=1, apply a 2^k shift to acc per op:
    - SLL: zero fill at LSBs.
    - SRL: zero fill at MSBs.
    - SRA: fill with acc[WIDTH-1].
  - If shamt[k]=0, acc is unchanged.
  - If shamt>>(k+1)==0, go to DONE; otherwise k=k+1.
- Latency: let N=0 if shamt==0, else (index of the highest set bit of shamt)+1, max 5. rsp_valid first goes high in the cycle after edge T+N, where T is the accept edge.
- DONE:
  - rsp_valid=1 and rsp_data=acc, both held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. The next request can be accepted no earlier than the following cycle.
- rsp_data is driven from acc in every state; it is only meaningful while rsp_valid=1.
- flush: highest priority apart from reset. In any state, at the next edge go to IDLE and drop the operation. No response is produced and acc is not cleared. If flush coincides with a request in IDLE, the request is not accepted; req_ready is combinationally low while flush=1.
- Request inputs are ignored outside IDLE. Holding req_valid high during busy must have no effect.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- Defined: op 11 = rotate left. Each stage rotates acc by 2^k; bits shifted out of the MSB re-enter at the LSB. Latency is the same as for shifts.
- Undefined: op 11 is executed exactly as SLL. No extra logic is generated.

Decomposition:
- Package shift_pkg holds:
  - op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROL;
  - state enum typedef shift_state_t;
  - WIDTH/SHAMT_W default localparams.
- Sub-module shift_stage: combinational single step. Inputs are acc, op and stage index k; output is acc shifted or rotated by 2^k. This is the only datapath instance.
- The FSM, handshakes and flush logic live in shift_seq_ctrl.

Test Plan:
- Reset behaviour: assert rst_n=0 mid-SHIFT -> outputs return to reset values immediately, without waiting for a clock edge.
- SLL with shamt=0: req_data=0x0000_00F0, req_shamt=0 -> rsp_valid in the cycle after accept, rsp_data=0x0000_00F0.
- SLL with shamt=4: req_data=0x0000_0001, req_shamt=4 -> rsp_valid 3 edges after accept (N=3), rsp_data=0x0000_0010.
- SRA with shamt=31: req_data=0x8000_0000, req_shamt=31 -> rsp_data=0xFFFF_FFFF after 5 SHIFT cycles. The same operand with SRL -> 0x0000_0001.
- Backpressure, then flush:
  - Hold rsp_ready=0 for 4 cycles in DONE -> rsp_valid and rsp_data stay stable; req_valid pulses during this time are not accepted.
  - Then assert flush during SHIFT -> IDLE at the next edge, no rsp_valid.
- Rotate, with SHIFT_SEQ_ROTATE_EN defined: op=11, req_data=0x8000_0001, shamt=1 -> rsp_data=0x0000_0003. With the macro undefined, the same request -> 0x0000_0002.
